wbm_bytes: RTL and testbench

Parametrised Wishbone B4 pipelined master driven by a full-duplex byte stream, successor to the single-word SPI-controlled master. Sits behind the SPI slave receiver/transmitter and their clock-domain import/export stages, entirely in the Wishbone clock domain. It adds:
- configurable address and data widths;
- bursts of 1–16 words with optional address auto-increment;
- bus error reporting;
- a stuck-slave timeout.

---
 rtl/wbm_bytes.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_wbm_bytes.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbm_bytes.sv
// wbm_bytes: Wishbone B4 pipelined master driven by a full-duplex byte stream.
// Each received byte yields exactly one transmitted byte one clock later.
// A frame carries header, byte select, address and per-word data. It runs
// 1..16 word bursts with optional address increment and reports ack, bus
// error or timeout through response tokens.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wb_cyc_o, wb_stb_o   bus cycle / strobe
//   wb_we_o, wb_sel_o    write enable / byte select
//   wb_adr_o, wb_dat_o   address / write data
//   wb_dat_i             read data
//   wb_stall_i, wb_ack_i, wb_err_i   slave handshake
//   rx_stb, rx_data      incoming byte strobe and value
//   tx_stb, tx_data      outgoing byte strobe and value
//   busy                 frame in progress (state not IDLE)
module wbm_bytes #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_stall_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  input  logic                rx_stb,
  input  logic [7:0]          rx_data,
  output logic                tx_stb,
  output logic [7:0]          tx_data,
  output logic                busy
);

  localparam int unsigned ABYTES = ADDR_W / 8;
  localparam int unsigned DBYTES = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [7:0] TOK_FILL = 8'h00;
  localparam logic [7:0] TOK_ACK  = 8'h55;
  localparam logic [7:0] TOK_ERR  = 8'hEE;
  localparam logic [7:0] TOK_TMO  = 8'hE7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_ADDR,
    S_WDATA,
    S_WAIT,
    S_RDATA
  } state_t;

  typedef enum logic [1:0] {
    R_NONE,
    R_ACK,
    R_ERR,
    R_TMO
  } res_t;

  state_t              state_q, state_d;
  res_t                res_q, res_d;
  logic                we_q, we_d;
  logic                inc_q, inc_d;
  logic [3:0]          words_q, words_d;
  logic [CNT_W-1:0]    byte_q, byte_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DBYTES-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic [DATA_W-1:0]   rd_q, rd_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic                tx_stb_q, tx_stb_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                busy_q, busy_d;

  logic                start_c;
  logic                to_hit_c;
  logic                last_a_c;
  logic                last_d_c;

  assign last_a_c = (byte_q == CNT_W'(ABYTES - 1));
  assign last_d_c = (byte_q == CNT_W'(DBYTES - 1));
  // Abort on the TIMEOUT-th clock with the cycle open; TIMEOUT of 0 never fires.
  assign to_hit_c = (TIMEOUT != 0) && (tcnt_q == TO_W'(TIMEOUT - 1));

  // Next-state and next-register logic: bus engine first, then byte FSM.
  always_comb begin
    state_d   = state_q;
    res_d     = res_q;
    we_d      = we_q;
    inc_d     = inc_q;
    words_d   = words_q;
    byte_d    = byte_q;
    adr_d     = adr_q;
    sel_d     = sel_q;
    dat_d     = dat_q;
    rd_d      = rd_q;
    tcnt_d    = tcnt_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    tx_stb_d  = rx_stb;
    tx_data_d = tx_data_q;
    start_c   = 1'b0;

    // Bus engine: strobe handshake, termination and timeout.
    if (cyc_q) begin
      tcnt_d = tcnt_q + TO_W'(1);
      if (stb_q && !wb_stall_i) begin
        stb_d = 1'b0;
      end
      if (wb_ack_i || wb_err_i) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        if (wb_err_i) begin
          res_d = R_ERR;
        end else begin
          res_d = R_ACK;
          if (!we_q) begin
            rd_d = wb_dat_i;
          end
        end
      end else if (to_hit_c) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
        res_d = R_TMO;
      end
    end

    // Byte FSM: one step per received byte.
    if (rx_stb) begin
      tx_data_d = TOK_FILL;
      unique case (state_q)
        S_IDLE: begin
          // Bytes without the frame marker (e.g. 0x00 fill) are skipped.
          if (rx_data[5]) begin
            we_d    = rx_data[7];
            inc_d   = rx_data[6];
            words_d = rx_data[3:0];
            byte_d  = '0;
            state_d = S_SEL;
          end
        end
        S_SEL: begin
          sel_d   = rx_data[DBYTES-1:0];
          byte_d  = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          adr_d = ADDR_W'({adr_q, rx_data});
          if (last_a_c) begin
            byte_d = '0;
            if (we_q) begin
              state_d = S_WDATA;
            end else begin
              start_c = 1'b1;
              state_d = S_WAIT;
            end
          end else begin
            byte_d = byte_q + CNT_W'(1);
          end
        end
        S_WDATA: begin
          dat_d = DATA_W'({dat_q, rx_data});
          if (last_d_c) begin
            byte_d  = '0;
            start_c = 1'b1;
            state_d = S_WAIT;
          end else begin
            byte_d = byte_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          // Token comes from the registered result, so an ack in this same
          // clock still answers fill; the token goes out on the next byte.
          if (res_q != R_NONE) begin
            res_d  = R_NONE;
            byte_d = '0;
            if (res_q == R_ACK) begin
              tx_data_d = TOK_ACK;
              if (!we_q) begin
                state_d = S_RDATA;
              end else if (words_q != 4'd0) begin
                words_d = words_q - 4'd1;
                adr_d   = adr_q + ADDR_W'(inc_q);
                state_d = S_WDATA;
              end else begin
                state_d = S_IDLE;
              end
            end else if (res_q == R_ERR) begin
              tx_data_d = TOK_ERR;
              state_d   = S_IDLE;
            end else begin
              tx_data_d = TOK_TMO;
              state_d   = S_IDLE;
            end
          end
        end
        S_RDATA: begin
          tx_data_d = rd_q[DATA_W-1 -: 8];
          rd_d      = DATA_W'({rd_q, 8'h00});
          if (last_d_c) begin
            byte_d = '0;
            if (words_q != 4'd0) begin
              words_d = words_q - 4'd1;
              adr_d   = adr_q + ADDR_W'(inc_q);
              start_c = 1'b1;
              state_d = S_WAIT;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            byte_d = byte_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Cycle launch; only requested while no cycle is open.
    if (start_c) begin
      cyc_d  = 1'b1;
      stb_d  = 1'b1;
      tcnt_d = '0;
      res_d  = R_NONE;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      res_q     <= R_NONE;
      we_q      <= 1'b0;
      inc_q     <= 1'b0;
      words_q   <= '0;
      byte_q    <= '0;
      adr_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      rd_q      <= '0;
      tcnt_q    <= '0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      tx_stb_q  <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      we_q      <= we_d;
      inc_q     <= inc_d;
      words_q   <= words_d;
      byte_q    <= byte_d;
      adr_q     <= adr_d;
      sel_q     <= sel_d;
      dat_q     <= dat_d;
      rd_q      <= rd_d;
      tcnt_q    <= tcnt_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      tx_stb_q  <= tx_stb_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = stb_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign tx_stb   = tx_stb_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wbm_bytes.sv
// Bench for wbm_bytes (ADDR_W=16, DATA_W=32, TIMEOUT=8): directed frames,
// a configurable slave, and a per-cycle comparison against a frame-level model.
module tb_wbm_bytes;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
  localparam int unsigned AB = AW / 8;
  localparam int unsigned DB = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [DB-1:0] wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_stall_i, wb_ack_i, wb_err_i;
  logic          rx_stb;
  logic [7:0]    rx_data;
  logic          tx_stb;
  logic [7:0]    tx_data;
  logic          busy;

  wbm_bytes #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .rx_stb(rx_stb), .rx_data(rx_data),
    .tx_stb(tx_stb), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { bit fill; logic [7:0] b; } txe_t;
  typedef struct { logic [AW-1:0] adr; logic [DB-1:0] sel; logic we; logic [DW-1:0] dat; } bus_t;

  txe_t        txq[$];
  bus_t        busq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        launch;
  logic [DW-1:0] fw [0:15];
  int          cfg_stall, cfg_delay, cfg_err_word;
  bit          cfg_never;
  logic [7:0]  last_tx;
  logic [DW-1:0] rd_got;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: stall for cfg_stall clocks, respond cfg_delay clocks after accept.
  int s_n = 0, s_word = 0, s_c;
  bit s_inflight = 0;
  bit s_resp;
  always @(negedge clk) begin
    if (rst || !wb_cyc_o) begin
      if (s_inflight) begin
        s_word++;
        s_inflight = 0;
      end
      if (!busy) s_word = 0;
      s_n = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_stall_i = 1'b0;
      wb_dat_i = $urandom;
    end else begin
      s_inflight = 1;
      s_c = s_n + 1;
      wb_stall_i = (s_c <= cfg_stall);
      s_resp = !cfg_never && (s_c == cfg_stall + 1 + cfg_delay);
      wb_err_i = s_resp && (s_word == cfg_err_word);
      wb_ack_i = s_resp && (s_word != cfg_err_word);
      wb_dat_i = fw[s_word];
      s_n++;
    end
  end

  // Compare process: frame model for tx stream, bus cycle timing and contents.
  bit   m_cyc = 0, m_stb = 0;
  int   m_hi = 0;
  logic p_cyc = 1'b0;
  int   stb_run = 0, cyc_run = 0, stb_len = 0, cyc_len = 0;
  bus_t cmp_b;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_cyc = 0; m_stb = 0; m_hi = 0; p_cyc = 1'b0; stb_run = 0; cyc_run = 0;
    end else begin
      chk("tx_stb_delay", tx_stb, rx_stb);
      if (tx_stb) begin
        if (txq.size() == 0) chk("tx_idle", tx_data, 8'h00);
        else if (!(txq[0].fill && tx_data == 8'h00)) begin
          chk("tx_data", tx_data, txq[0].b);
          void'(txq.pop_front());
        end
      end
      if (m_cyc) begin
        m_hi++;
        if (wb_ack_i || wb_err_i) begin m_cyc = 0; m_stb = 0; end
        else if (m_hi == TO) begin m_cyc = 0; m_stb = 0; end
        else if (m_stb && !wb_stall_i) m_stb = 0;
      end else if (rx_stb && launch) begin
        m_cyc = 1; m_stb = 1; m_hi = 0;
      end
      chk("cyc", wb_cyc_o, m_cyc);
      chk("stb", wb_stb_o, m_stb);
      if (wb_cyc_o && !p_cyc) begin
        if (busq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL bus_cycle: unexpected cycle at adr %0h, required none", wb_adr_o);
        end else begin
          cmp_b = busq.pop_front();
          chk("bus_adr", wb_adr_o, cmp_b.adr);
          chk("bus_sel", wb_sel_o, cmp_b.sel);
          chk("bus_we", wb_we_o, cmp_b.we);
          if (cmp_b.we) chk("bus_dat", wb_dat_o, cmp_b.dat);
        end
      end
      if (wb_stb_o) stb_run++;
      else if (stb_run != 0) begin stb_len = stb_run; stb_run = 0; end
      if (wb_cyc_o) cyc_run++;
      else if (cyc_run != 0) begin cyc_len = cyc_run; cyc_run = 0; end
      p_cyc = wb_cyc_o;
    end
  end

  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    rx_stb = 1'b1; rx_data = d; launch = l;
    @(negedge clk);
    rx_stb = 1'b0; launch = 1'b0;
    last_tx = tx_data;
  endtask

  task automatic expect_tx(input bit f, input logic [7:0] v);
    txe_t e;
    e.fill = f; e.b = v;
    txq.push_back(e);
  endtask

  task automatic run_frame(input logic we, input logic inc, input logic [3:0] len,
                           input logic [DB-1:0] sel, input logic [AW-1:0] adr);
    logic [7:0] hdr, tok;
    bus_t bt;
    int ncyc, budget;
    hdr = {we, inc, 1'b1, 1'b0, len};
    ncyc = cfg_never ? 1 : (cfg_err_word >= 0 ? cfg_err_word + 1 : int'(len) + 1);
    for (int w = 0; w < ncyc; w++) begin
      bt.adr = AW'(adr + (inc ? w : 0));
      bt.sel = sel; bt.we = we; bt.dat = fw[w];
      busq.push_back(bt);
    end
    rd_got = '0;
    expect_tx(0, 8'h00); send(hdr, 1'b0);
    expect_tx(0, 8'h00); send({4'h0, sel}, 1'b0);
    for (int i = 0; i < int'(AB); i++) begin
      expect_tx(0, 8'h00);
      send(8'(adr >> (8 * (int'(AB) - 1 - i))), (i == int'(AB) - 1) && !we);
    end
    for (int w = 0; w <= int'(len); w++) begin
      if (we) begin
        for (int i = 0; i < int'(DB); i++) begin
          expect_tx(0, 8'h00);
          send(8'(fw[w] >> (8 * (int'(DB) - 1 - i))), i == int'(DB) - 1);
        end
      end
      tok = cfg_never ? 8'hE7 : ((w == cfg_err_word) ? 8'hEE : 8'h55);
      expect_tx(1, tok);
      budget = 0;
      last_tx = 8'h00;
      while (last_tx == 8'h00 && budget < 40) begin
        send(8'h00, 1'b0);
        budget++;
      end
      chk("token", last_tx, tok);
      if (last_tx == 8'h00) return;
      if (tok != 8'h55) break;
      if (!we) begin
        for (int i = 0; i < int'(DB); i++) begin
          expect_tx(0, 8'(fw[w] >> (8 * (int'(DB) - 1 - i))));
          send(8'h00, (i == int'(DB) - 1) && (w < int'(len)));
          rd_got = {rd_got[DW-9:0], last_tx};
        end
      end
    end
    repeat (3) @(negedge clk);
    chk("busy_end", busy, 1'b0);
    chk("bus_all_issued", busq.size(), 0);
    chk("tx_all_seen", txq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_stb = 1'b0; rx_data = 8'h00; launch = 1'b0;
    cfg_stall = 0; cfg_delay = 0; cfg_err_word = -1; cfg_never = 0;
    last_tx = 8'h00; rd_got = '0;
    for (int i = 0; i < 16; i++) fw[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_sel", wb_sel_o, 4'h0);
    chk("rst_adr", wb_adr_o, 16'h0000);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_tx_stb", tx_stb, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single read.
    fw[0] = 32'hDEADBEEF; cfg_delay = 1;
    run_frame(1'b0, 1'b0, 4'd0, 4'hF, 16'h1234);
    chk("t1_rdata", rd_got, 32'hDEADBEEF);

    // Burst write with increment.
    fw[0] = 32'h11223344; fw[1] = 32'h55667788; cfg_delay = 0;
    run_frame(1'b1, 1'b1, 4'd1, 4'h3, 16'h0100);

    // Stall for 5 clocks.
    fw[0] = 32'hCAFEF00D; cfg_stall = 5;
    run_frame(1'b0, 1'b0, 4'd0, 4'h1, 16'h0042);
    chk("t3_stb_len", stb_len, 6);
    chk("t3_rdata", rd_got, 32'hCAFEF00D);
    cfg_stall = 0;

    // Error on second word of a 3-word read, address wraps.
    fw[0] = 32'h01020304; fw[1] = 32'hA5A5A5A5; fw[2] = 32'h0F0F0F0F;
    cfg_delay = 2; cfg_err_word = 1;
    run_frame(1'b0, 1'b1, 4'd2, 4'hF, 16'hFFFF);
    chk("t4_rdata", rd_got, 32'h01020304);
    cfg_err_word = -1; cfg_delay = 0;

    // Timeout; then fill is ignored in IDLE.
    cfg_never = 1;
    run_frame(1'b0, 1'b0, 4'd0, 4'hF, 16'h0BAD);
    chk("t5_cyc_len", cyc_len, 8);
    for (int i = 0; i < 3; i++) begin
      expect_tx(0, 8'h00);
      send(8'h00, 1'b0);
      chk("t5_fill_busy", busy, 1'b0);
    end

    // Asynchronous reset while the cycle is open.
    bus_reset_setup();
    @(negedge clk);
    rx_stb = 1'b1; rx_data = 8'h78; launch = 1'b1;
    @(posedge clk);
    #3;
    chk("t6_cyc_started", wb_cyc_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_cyc", wb_cyc_o, 1'b0);
    chk("t6_rst_stb", wb_stb_o, 1'b0);
    chk("t6_rst_tx_stb", tx_stb, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    rx_stb = 1'b0; launch = 1'b0;
    txq.delete(); busq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cfg_never = 0;
    repeat (2) @(negedge clk);
    fw[0] = 32'h89ABCDEF;
    run_frame(1'b0, 1'b1, 4'd0, 4'hF, 16'h5678);
    chk("t6_rdata", rd_got, 32'h89ABCDEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Header, SEL and first address byte of a read that the reset will cut.
  task automatic bus_reset_setup();
    bus_t bt;
    bt.adr = 16'h5678; bt.sel = 4'hF; bt.we = 1'b0; bt.dat = '0;
    busq.push_back(bt);
    expect_tx(0, 8'h00); send(8'h20, 1'b0);
    expect_tx(0, 8'h00); send(8'h0F, 1'b0);
    expect_tx(0, 8'h00); send(8'h56, 1'b0);
    expect_tx(0, 8'h00);
  endtask

endmodule
